// File: rtl/spi_instruction_decoder_pkg.sv
// Shared opcode and FSM state encodings for the SPI instruction decoder.
package TitanComms;

    typedef enum logic [7:0] {
        OP_NOP      = 8'd0,
        OP_WRITE    = 8'd1,
        OP_READ     = 8'd2,
        OP_STREAM   = 8'd3,
        OP_TRANSFER = 8'd4,
        OP_REPEAT   = 8'd5
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/spi_instruction_decoder_tx.sv
// Holds the read-back capture word and serves it MSB-first, one byte per load request.
module spi_tx_serializer #(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture_en_i,
    input  logic [VALUE_WIDTH-1:0] capture_value_i,
    input  logic                   load_en_i,
    input  logic                   rewind_en_i,
    output logic [7:0]             spi_tx_byte_o,
    output logic                   spi_tx_load_o
);

    localparam int VAL_BYTES = VALUE_WIDTH / 8;
    localparam int PTR_W     = (VAL_BYTES > 1) ? $clog2(VAL_BYTES) : 1;

    logic [VALUE_WIDTH-1:0] cap_q, cap_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             byte_q, byte_d;
    logic                   load_q, load_d;
    logic [VALUE_WIDTH-1:0] shifted;

    // Shifting left by the pointer puts the selected byte in the top lane.
    assign shifted = cap_q << {ptr_q, 3'b000};

    always_comb begin
        cap_d  = cap_q;
        ptr_d  = ptr_q;
        byte_d = byte_q;
        load_d = 1'b0;
        if (capture_en_i) begin
            cap_d = capture_value_i;
            ptr_d = '0;
        end else if (rewind_en_i) begin
            ptr_d = '0;
        end else if (load_en_i) begin
            byte_d = shifted[VALUE_WIDTH-1 -: 8];
            load_d = 1'b1;
            ptr_d  = (ptr_q == PTR_W'(VAL_BYTES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            ptr_q  <= '0;
            byte_q <= '0;
            load_q <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            ptr_q  <= ptr_d;
            byte_q <= byte_d;
            load_q <= load_d;
        end
    end

    assign spi_tx_byte_o = byte_q;
    assign spi_tx_load_o = load_q;

endmodule

// File: rtl/spi_instruction_decoder.sv
// Turns opcode/address/value byte streams from the SPI slave into single-cycle
// core bus transactions, and hands captured read data to the tx serializer.
module spi_instruction_decoder
    import TitanComms::*;
#(
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_rx_valid,
    input  logic [7:0]                   spi_rx_byte,
    input  logic [VALUE_WIDTH-1:0]       value_from_core,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_bus,
    output logic [ADDRESS_WIDTH-1:0]     address_bus,
    output logic [VALUE_WIDTH-1:0]       value_bus,
    output logic                         bus_valid,
    output logic [7:0]                   spi_tx_byte,
    output logic                         spi_tx_load,
    output logic                         busy,
    output logic                         opcode_error
);

    localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int VAL_BYTES  = VALUE_WIDTH / 8;

    state_e                         state_q, state_d;
    opcode_e                        opcode_q, opcode_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [8:0]                     words_q, words_d;
    logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
    logic [VALUE_WIDTH-1:0]         word_q, word_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0]       abus_q, abus_d;
    logic [VALUE_WIDTH-1:0]         vbus_q, vbus_d;
    logic                           valid_q, valid_d;
    logic                           err_q, err_d;
    logic                           tx_load_en, tx_rewind_en, cap_en;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        cnt_d        = cnt_q;
        words_d      = words_q;
        addr_d       = addr_q;
        word_d       = word_q;
        instr_d      = instr_q;
        abus_d       = abus_q;
        vbus_d       = vbus_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        tx_load_en   = 1'b0;
        tx_rewind_en = 1'b0;
        cap_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spi_rx_valid) begin
                    case (spi_rx_byte)
                        OP_WRITE, OP_READ, OP_STREAM: begin
                            opcode_d = opcode_e'(spi_rx_byte);
                            cnt_d    = '0;
                            state_d  = ST_ADDR;
                        end
                        OP_TRANSFER: tx_load_en   = 1'b1;
                        OP_REPEAT:   tx_rewind_en = 1'b1;
                        OP_NOP:      ;
                        default:     err_d = 1'b1;
                    endcase
                end
            end

            ST_ADDR: begin
                if (spi_rx_valid) begin
                    addr_d = (addr_q << 8) | ADDRESS_WIDTH'(spi_rx_byte);
                    if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                        cnt_d = '0;
                        case (opcode_q)
                            OP_READ: begin
                                valid_d = 1'b1;
                                instr_d = INSTRUCTION_WIDTH'(opcode_q);
                                abus_d  = addr_d;
                                vbus_d  = '0;
                                state_d = ST_CAPTURE;
                            end
                            OP_WRITE: begin
                                words_d = 9'd1;
                                state_d = ST_DATA;
                            end
                            default: state_d = ST_LEN;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_LEN: begin
                if (spi_rx_valid) begin
                    words_d = (spi_rx_byte == 8'd0) ? 9'd256 : {1'b0, spi_rx_byte};
                    state_d = ST_DATA;
                end
            end

            // addr_q doubles as the running word address, so wrap-around is free.
            ST_DATA: begin
                if (spi_rx_valid) begin
                    word_d = (word_q << 8) | VALUE_WIDTH'(spi_rx_byte);
                    if (cnt_q == 8'(VAL_BYTES - 1)) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        instr_d = INSTRUCTION_WIDTH'(opcode_q);
                        abus_d  = addr_q;
                        vbus_d  = word_d;
                        addr_d  = addr_q + ADDRESS_WIDTH'(1);
                        words_d = words_q - 9'd1;
                        if (words_q == 9'd1) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            // Core read data arrives the cycle after the strobe, so wait it out.
            ST_CAPTURE: begin
                if (!valid_q) begin
                    cap_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_NOP;
            cnt_q    <= '0;
            words_q  <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            instr_q  <= '0;
            abus_q   <= '0;
            vbus_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
            words_q  <= words_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            instr_q  <= instr_d;
            abus_q   <= abus_d;
            vbus_q   <= vbus_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    spi_tx_serializer #(
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_tx (
        .clk             (clk),
        .rst_n           (rst_n),
        .capture_en_i    (cap_en),
        .capture_value_i (value_from_core),
        .load_en_i       (tx_load_en),
        .rewind_en_i     (tx_rewind_en),
        .spi_tx_byte_o   (spi_tx_byte),
        .spi_tx_load_o   (spi_tx_load)
    );

    assign instruction_bus = instr_q;
    assign address_bus     = abus_q;
    assign value_bus       = vbus_q;
    assign bus_valid       = valid_q;
    assign opcode_error    = err_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_instruction_decoder.sv
// Bench for spi_instruction_decoder: default-width instance plus a 16-bit address / 64-bit value instance.
module tb_spi_instruction_decoder;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [63:0] value;
    } busTxn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rxValid1 = 1'b0, rxValid2 = 1'b0;
    logic [7:0]  rxByte1 = '0, rxByte2 = '0;
    logic [31:0] coreValue1 = '0;
    logic [63:0] coreValue2 = '0;

    logic [7:0]  instr1, instr2;
    logic [23:0] addr1;
    logic [15:0] addr2;
    logic [31:0] value1;
    logic [63:0] value2;
    logic        busValid1, busValid2, txLoad1, txLoad2, busy1, busy2, err1, err2;
    logic [7:0]  txByte1, txByte2;

    int testsRun = 0;
    int testsFailed = 0;
    int strobes1 = 0;

    busTxn_t     busQ1[$], busQ2[$];
    logic [7:0]  txQ1[$], txQ2[$];
    busTxn_t     exp;
    logic [7:0]  expByte;

    // Reference model of each capture register and its byte pointer.
    logic [63:0] capModel1 = '0, capModel2 = '0;
    int          ptrModel1 = 0, ptrModel2 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (busValid1) strobes1++;

    spi_instruction_decoder dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_rx_valid    (rxValid1),
        .spi_rx_byte     (rxByte1),
        .value_from_core (coreValue1),
        .instruction_bus (instr1),
        .address_bus     (addr1),
        .value_bus       (value1),
        .bus_valid       (busValid1),
        .spi_tx_byte     (txByte1),
        .spi_tx_load     (txLoad1),
        .busy            (busy1),
        .opcode_error    (err1)
    );

    spi_instruction_decoder #(
        .INSTRUCTION_WIDTH(8),
        .ADDRESS_WIDTH(16),
        .VALUE_WIDTH(64)
    ) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_rx_valid    (rxValid2),
        .spi_rx_byte     (rxByte2),
        .value_from_core (coreValue2),
        .instruction_bus (instr2),
        .address_bus     (addr2),
        .value_bus       (value2),
        .bus_valid       (busValid2),
        .spi_tx_byte     (txByte2),
        .spi_tx_load     (txLoad2),
        .busy            (busy2),
        .opcode_error    (err2)
    );

    // One byte per call; on return (next falling edge) the registered response is visible.
    task automatic applyStimulus(input int port, input logic [7:0] b);
        @(negedge clk);
        if (port == 1) begin
            rxValid1 = 1'b1;
            rxByte1  = b;
        end else begin
            rxValid2 = 1'b1;
            rxByte2  = b;
        end
        @(negedge clk);
        rxValid1 = 1'b0;
        rxValid2 = 1'b0;
    endtask

    function automatic logic [7:0] modelByte(input logic [63:0] cap, input int nBytes, input int ptr);
        logic [63:0] t;
        t = cap >> (8 * (nBytes - 1 - ptr));
        return t[7:0];
    endfunction

    task automatic pushTx1();
        txQ1.push_back(modelByte(capModel1, 4, ptrModel1));
        ptrModel1 = (ptrModel1 + 1) % 4;
    endtask

    task automatic pushTx2();
        txQ2.push_back(modelByte(capModel2, 8, ptrModel2));
        ptrModel2 = (ptrModel2 + 1) % 8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({instr1, addr1, value1, busValid1, txByte1, txLoad1, busy1, err1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_dut1: got %h, expected 0",
                     {instr1, addr1, value1, busValid1, txByte1, txLoad1, busy1, err1});
        end
        testsRun++;
        if ({instr2, addr2, value2, busValid2, txByte2, txLoad2, busy2, err2} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_dut2: got %h, expected 0",
                     {instr2, addr2, value2, busValid2, txByte2, txLoad2, busy2, err2});
        end
        rst_n = 1'b1;
        capModel1 = '0; ptrModel1 = 0;
        capModel2 = '0; ptrModel2 = 0;
        // TRANSFER with nothing captured yet returns zero.
        pushTx1();
        applyStimulus(1, 8'h04);
        expByte = txQ1.pop_front();
        testsRun++;
        if (txLoad1 !== 1'b1 || txByte1 !== expByte) begin
            testsFailed++;
            $display("[TB] FAIL transfer_after_reset: got load=%b byte=%h, expected load=1 byte=%h",
                     txLoad1, txByte1, expByte);
        end
    endtask

    task automatic test_write();
        logic [7:0] seq[$];
        seq = '{8'h01, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        busQ1.push_back('{32'h01, 32'h000010, 64'hDEADBEEF});
        foreach (seq[i]) applyStimulus(1, seq[i]);
        exp = busQ1.pop_front();
        testsRun++;
        if ({busValid1, 32'(instr1), 32'(addr1), 64'(value1)} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
            testsFailed++;
            $display("[TB] FAIL write_txn: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                     busValid1, instr1, addr1, value1, exp.instr, exp.addr, exp.value);
        end
        testsRun++;
        if (busy1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_busy_falls: got %b, expected 0", busy1);
        end
        @(negedge clk);
        testsRun++;
        if (busValid1 !== 1'b0 || value1 !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL write_strobe_one_cycle: got v=%b d=%h, expected v=0 d=deadbeef", busValid1, value1);
        end
    endtask

    task automatic test_read_transfer();
        logic [7:0] seq[$];
        seq = '{8'h02, 8'h00, 8'h00, 8'h20};
        coreValue1 = 32'h12345678;
        busQ1.push_back('{32'h02, 32'h000020, 64'h0});
        foreach (seq[i]) applyStimulus(1, seq[i]);
        exp = busQ1.pop_front();
        testsRun++;
        if ({busValid1, 32'(instr1), 32'(addr1), 64'(value1)} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
            testsFailed++;
            $display("[TB] FAIL read_txn: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                     busValid1, instr1, addr1, value1, exp.instr, exp.addr, exp.value);
        end
        testsRun++;
        if (busy1 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL read_busy_capture: got %b, expected 1", busy1);
        end
        capModel1 = {32'h0, coreValue1};
        ptrModel1 = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            pushTx1();
            applyStimulus(1, 8'h04);
            expByte = txQ1.pop_front();
            testsRun++;
            if (txLoad1 !== 1'b1 || txByte1 !== expByte) begin
                testsFailed++;
                $display("[TB] FAIL transfer_%0d: got load=%b byte=%h, expected load=1 byte=%h",
                         k, txLoad1, txByte1, expByte);
            end
        end
        applyStimulus(1, 8'h05);
        ptrModel1 = 0;
        testsRun++;
        if (txLoad1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL repeat_no_load: got %b, expected 0", txLoad1);
        end
        pushTx1();
        applyStimulus(1, 8'h04);
        expByte = txQ1.pop_front();
        testsRun++;
        if (txLoad1 !== 1'b1 || txByte1 !== expByte) begin
            testsFailed++;
            $display("[TB] FAIL transfer_after_repeat: got load=%b byte=%h, expected load=1 byte=%h",
                     txLoad1, txByte1, expByte);
        end
    endtask

    task automatic test_stream();
        logic [7:0] hdr[$];
        hdr = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h02};
        busQ1.push_back('{32'h03, 32'hFFFFFF, 64'h11111111});
        busQ1.push_back('{32'h03, 32'h000000, 64'h22222222});
        foreach (hdr[i]) applyStimulus(1, hdr[i]);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) applyStimulus(1, (w == 0) ? 8'h11 : 8'h22);
            exp = busQ1.pop_front();
            testsRun++;
            if ({busValid1, 32'(instr1), 32'(addr1), 64'(value1)} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
                testsFailed++;
                $display("[TB] FAIL stream_word_%0d: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                         w, busValid1, instr1, addr1, value1, exp.instr, exp.addr, exp.value);
            end
        end
        testsRun++;
        if (busy1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stream_busy_falls: got %b, expected 0", busy1);
        end
    endtask

    task automatic test_opcode_error();
        int s0;
        @(negedge clk);
        s0 = strobes1;
        applyStimulus(1, 8'h07);
        testsRun++;
        if ({err1, busValid1, busy1} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL unknown_opcode: got err=%b v=%b busy=%b, expected err=1 v=0 busy=0",
                     err1, busValid1, busy1);
        end
        @(negedge clk);
        testsRun++;
        if (err1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL error_one_cycle: got %b, expected 0", err1);
        end
        applyStimulus(1, 8'h00);
        testsRun++;
        if ({err1, busValid1, busy1, txLoad1} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL nop_byte: got err=%b v=%b busy=%b load=%b, expected all 0",
                     err1, busValid1, busy1, txLoad1);
        end
        @(negedge clk);
        testsRun++;
        if (strobes1 !== s0) begin
            testsFailed++;
            $display("[TB] FAIL error_no_strobe: got %0d strobes, expected %0d", strobes1, s0);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] seq[$];
        int s0;
        s0 = strobes1;
        applyStimulus(1, 8'h01);
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({instr1, addr1, value1, busValid1, txByte1, txLoad1, busy1, err1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL abort_reset_outputs: got %h, expected 0",
                     {instr1, addr1, value1, busValid1, txByte1, txLoad1, busy1, err1});
        end
        rst_n = 1'b1;
        capModel1 = '0; ptrModel1 = 0;
        capModel2 = '0; ptrModel2 = 0;
        seq = '{8'h01, 8'h12, 8'h34, 8'h56, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        busQ1.push_back('{32'h01, 32'h123456, 64'hCAFEBABE});
        foreach (seq[i]) applyStimulus(1, seq[i]);
        exp = busQ1.pop_front();
        testsRun++;
        if ({busValid1, 32'(instr1), 32'(addr1), 64'(value1)} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
            testsFailed++;
            $display("[TB] FAIL abort_then_write: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                     busValid1, instr1, addr1, value1, exp.instr, exp.addr, exp.value);
        end
        @(negedge clk);
        testsRun++;
        if (strobes1 !== s0 + 1) begin
            testsFailed++;
            $display("[TB] FAIL abort_strobe_count: got %0d, expected %0d", strobes1, s0 + 1);
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0] seq[$];
        seq = '{8'h01, 8'hAB, 8'hCD, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        busQ2.push_back('{32'h01, 32'hABCD, 64'h0123456789ABCDEF});
        foreach (seq[i]) applyStimulus(2, seq[i]);
        exp = busQ2.pop_front();
        testsRun++;
        if ({busValid2, 32'(instr2), 32'(addr2), value2} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
            testsFailed++;
            $display("[TB] FAIL wide_write_txn: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                     busValid2, instr2, addr2, value2, exp.instr, exp.addr, exp.value);
        end
        coreValue2 = 64'hA1B2C3D4E5F60718;
        seq = '{8'h02, 8'h00, 8'h40};
        busQ2.push_back('{32'h02, 32'h0040, 64'h0});
        foreach (seq[i]) applyStimulus(2, seq[i]);
        exp = busQ2.pop_front();
        testsRun++;
        if ({busValid2, 32'(instr2), 32'(addr2), value2} !== {1'b1, exp.instr, exp.addr, exp.value}) begin
            testsFailed++;
            $display("[TB] FAIL wide_read_txn: got v=%b i=%h a=%h d=%h, expected v=1 i=%h a=%h d=%h",
                     busValid2, instr2, addr2, value2, exp.instr, exp.addr, exp.value);
        end
        capModel2 = coreValue2;
        ptrModel2 = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            pushTx2();
            applyStimulus(2, 8'h04);
            expByte = txQ2.pop_front();
            testsRun++;
            if (txLoad2 !== 1'b1 || txByte2 !== expByte) begin
                testsFailed++;
                $display("[TB] FAIL wide_transfer_%0d: got load=%b byte=%h, expected load=1 byte=%h",
                         k, txLoad2, txByte2, expByte);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_transfer();
        test_stream();
        test_opcode_error();
        test_reset_abort();
        test_param_sweep();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
